fetch_sequencer: RTL and testbench

Instruction-fetch sequencer that sits between the program memory and the instruction register. It owns the fetch program counter and issues handshaked read requests to memory. It holds each fetched 8-bit instruction until the controller accepts it, which is when the controller asserts its IR load. It also redirects fetch on a jump to a 4-bit immediate target, discarding any instructions that were fetched after the jump.

---
 rtl/fetch_sequencer.sv | 160 ++++++++++++++++
 tb/tb_fetch_sequencer.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - instruction-fetch sequencer: fetch PC, memory request handshake, instruction hold buffer, jump redirect
// Optional FETCH_PREFETCH_EN: two-entry buffer (head + prefetch) for one instruction per cycle.
module fetch_sequencer #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              i_clk,
  input  logic              i_reset,
  output logic              o_mem_req,
  output logic [ADDR_W-1:0] o_mem_addr,
  input  logic              i_mem_ack,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic              o_instr_valid,
  output logic [DATA_W-1:0] o_instr,
  output logic [ADDR_W-1:0] o_instr_pc,
  input  logic              i_instr_ready,
  input  logic              i_jump,
  input  logic [ADDR_W-1:0] i_jump_addr
);

  typedef enum logic [1:0] {S_START, S_FETCH, S_DISCARD, S_FULL} state_t;

  state_t            r_state, w_state;
  logic [ADDR_W-1:0] r_pc, w_pc;
  logic [ADDR_W-1:0] r_target, w_target;
  logic              r_valid, w_valid;
  logic [DATA_W-1:0] r_instr, w_instr;
  logic [ADDR_W-1:0] r_instr_pc, w_instr_pc;
`ifdef FETCH_PREFETCH_EN
  logic              r_pf_valid, w_pf_valid;
  logic [DATA_W-1:0] r_pf_instr, w_pf_instr;
  logic [ADDR_W-1:0] r_pf_pc, w_pf_pc;
`endif

  logic w_xfer;
  logic w_consume;

  // Outputs depend on registered state only; r_pc stays at the pending address in DISCARD.
`ifdef FETCH_PREFETCH_EN
  assign o_mem_req = (r_state == S_FETCH) || (r_state == S_DISCARD) ||
                     ((r_state == S_FULL) && !r_pf_valid);
`else
  assign o_mem_req = (r_state == S_FETCH) || (r_state == S_DISCARD);
`endif
  assign o_mem_addr    = r_pc;
  assign o_instr_valid = r_valid;
  assign o_instr       = r_instr;
  assign o_instr_pc    = r_instr_pc;

  assign w_xfer    = o_mem_req && i_mem_ack;
  assign w_consume = r_valid && i_instr_ready;

  always_comb begin
    w_state    = r_state;
    w_pc       = r_pc;
    w_target   = r_target;
    w_valid    = r_valid;
    w_instr    = r_instr;
    w_instr_pc = r_instr_pc;
`ifdef FETCH_PREFETCH_EN
    w_pf_valid = r_pf_valid;
    w_pf_instr = r_pf_instr;
    w_pf_pc    = r_pf_pc;
`endif
    case (r_state)
      S_START: w_state = S_FETCH;
      S_FETCH, S_FULL: begin
        if (i_jump) begin
          // Jump beats consume: everything buffered is flushed.
          w_valid    = 1'b0;
          w_instr    = '0;
          w_instr_pc = '0;
`ifdef FETCH_PREFETCH_EN
          w_pf_valid = 1'b0;
          w_pf_instr = '0;
          w_pf_pc    = '0;
`endif
          if (w_xfer || !o_mem_req) begin
            w_pc    = i_jump_addr;
            w_state = S_FETCH;
          end else begin
            w_target = i_jump_addr;
            w_state  = S_DISCARD;
          end
        end else begin
          if (w_consume) begin
`ifdef FETCH_PREFETCH_EN
            w_valid    = r_pf_valid;
            w_instr    = r_pf_instr;
            w_instr_pc = r_pf_pc;
            w_pf_valid = 1'b0;
            w_pf_instr = '0;
            w_pf_pc    = '0;
`else
            w_valid    = 1'b0;
            w_instr    = '0;
            w_instr_pc = '0;
`endif
          end
          if (w_xfer) begin
`ifdef FETCH_PREFETCH_EN
            if (w_valid) begin
              w_pf_valid = 1'b1;
              w_pf_instr = i_mem_rdata;
              w_pf_pc    = r_pc;
            end else begin
              w_valid    = 1'b1;
              w_instr    = i_mem_rdata;
              w_instr_pc = r_pc;
            end
`else
            w_valid    = 1'b1;
            w_instr    = i_mem_rdata;
            w_instr_pc = r_pc;
`endif
            w_pc = r_pc + ADDR_W'(1);
          end
          w_state = w_valid ? S_FULL : S_FETCH;
        end
      end
      S_DISCARD: begin
        if (i_jump) w_target = i_jump_addr;
        if (w_xfer) begin
          w_pc    = i_jump ? i_jump_addr : r_target;
          w_state = S_FETCH;
        end
      end
      default: w_state = S_START;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= S_START;
      r_pc       <= '0;
      r_target   <= '0;
      r_valid    <= 1'b0;
      r_instr    <= '0;
      r_instr_pc <= '0;
`ifdef FETCH_PREFETCH_EN
      r_pf_valid <= 1'b0;
      r_pf_instr <= '0;
      r_pf_pc    <= '0;
`endif
    end else begin
      r_state    <= w_state;
      r_pc       <= w_pc;
      r_target   <= w_target;
      r_valid    <= w_valid;
      r_instr    <= w_instr;
      r_instr_pc <= w_instr_pc;
`ifdef FETCH_PREFETCH_EN
      r_pf_valid <= w_pf_valid;
      r_pf_instr <= w_pf_instr;
      r_pf_pc    <= w_pf_pc;
`endif
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - directed self-checking bench for fetch_sequencer (single-entry build)
module tb_fetch_sequencer;

  logic       clk;
  logic       reset;
  logic       mem_req;
  logic [3:0] mem_addr;
  logic       mem_ack;
  logic [7:0] mem_rdata;
  logic       instr_valid;
  logic [7:0] instr;
  logic [3:0] instr_pc;
  logic       instr_ready;
  logic       jump;
  logic [3:0] jump_addr;

  int n_pass  = 0;
  int n_total = 0;

  fetch_sequencer #(.ADDR_W(4), .DATA_W(8)) dut (
    .i_clk         (clk),
    .i_reset       (reset),
    .o_mem_req     (mem_req),
    .o_mem_addr    (mem_addr),
    .i_mem_ack     (mem_ack),
    .i_mem_rdata   (mem_rdata),
    .o_instr_valid (instr_valid),
    .o_instr       (instr),
    .o_instr_pc    (instr_pc),
    .i_instr_ready (instr_ready),
    .i_jump        (jump),
    .i_jump_addr   (jump_addr)
  );

  assign mem_rdata = 8'h10 + {4'h0, mem_addr};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_fetch(input string tag, input logic [3:0] addr);
    chk({tag, "_req"}, 32'(mem_req), 32'd1);
    chk({tag, "_addr"}, 32'(mem_addr), 32'(addr));
    chk({tag, "_vld"}, 32'(instr_valid), 32'd0);
    chk({tag, "_instr0"}, 32'(instr), 32'd0);
  endtask

  task automatic chk_full(input string tag, input logic [3:0] pc);
    chk({tag, "_vld"}, 32'(instr_valid), 32'd1);
    chk({tag, "_instr"}, 32'(instr), 32'h10 + 32'(pc));
    chk({tag, "_pc"}, 32'(instr_pc), 32'(pc));
    chk({tag, "_noreq"}, 32'(mem_req), 32'd0);
  endtask

  initial begin
    reset = 1'b1; mem_ack = 1'b1; instr_ready = 1'b1; jump = 1'b0; jump_addr = 4'h0;
    @(negedge clk);
    step();
    chk("rst_req", 32'(mem_req), 32'd0);
    chk("rst_addr", 32'(mem_addr), 32'd0);
    chk("rst_vld", 32'(instr_valid), 32'd0);
    chk("rst_instr", 32'(instr), 32'd0);
    chk("rst_pc", 32'(instr_pc), 32'd0);

    // Stream with zero-wait memory: one instruction every two cycles, 17 fetches to cross the wrap.
    reset = 1'b0;
    step();
    chk_fetch("first_req", 4'd0);
    step();
    chk_full("first_instr", 4'd0);
    for (int k = 1; k <= 16; k++) begin
      step();
      chk_fetch("stream_req", 4'(k));
      step();
      chk_full("stream_instr", 4'(k));
    end

    step();
    chk_fetch("bp_pre1", 4'd1);
    step();
    chk_full("bp_pre2", 4'd1);
    step();
    chk_fetch("bp_pre3", 4'd2);
    instr_ready = 1'b0;
    step();
    chk_full("bp_load", 4'd2);
    for (int i = 0; i < 5; i++) begin
      step();
      chk_full("bp_hold", 4'd2);
    end
    instr_ready = 1'b1;
    step();
    chk_fetch("bp_release", 4'd3);

    // Jump while the request at address 3 waits for its ack.
    mem_ack = 1'b0;
    step();
    chk_fetch("wait_stable", 4'd3);
    jump = 1'b1; jump_addr = 4'd9;
    step();
    chk_fetch("disc_hold", 4'd3);
    jump = 1'b0;
    step();
    chk_fetch("disc_hold2", 4'd3);
    mem_ack = 1'b1;
    step();
    chk_fetch("disc_redirect", 4'd9);
    step();
    chk_full("jump_target", 4'd9);

    jump = 1'b1; jump_addr = 4'd5;
    step();
    chk_fetch("jump_vs_consume", 4'd5);
    jump = 1'b0;
    step();
    chk_full("jvc_instr", 4'd5);

    step();
    chk_fetch("xj_pre", 4'd6);
    jump = 1'b1; jump_addr = 4'd12;
    step();
    chk_fetch("xfer_jump", 4'd12);
    jump = 1'b0;
    step();
    chk_full("xj_instr", 4'd12);

    step();
    chk_fetch("mr_pre", 4'd13);
    mem_ack = 1'b0;
    reset = 1'b1;
    step();
    chk("mr_req", 32'(mem_req), 32'd0);
    chk("mr_vld", 32'(instr_valid), 32'd0);
    chk("mr_addr", 32'(mem_addr), 32'd0);
    reset = 1'b0; mem_ack = 1'b1;
    step();
    chk_fetch("mr_resume", 4'd0);
    step();
    chk_full("mr_instr", 4'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
